// File: rtl/count_step_monitor.sv
`default_nettype none
// ============================================================================
// Module   : count_step_monitor
// Purpose  : Watches the value of an upstream 3-bit up counter, acquires lock
//            after a run of consecutive +1 steps, and then reports each 7->0
//            wrap. The first out-of-sequence value seen while locked is
//            captured, and the block parks in FAULT until clr or rst.
// Ports    : clk        - single clock, rising edge
//            rst        - asynchronous reset, active low
//            clr        - synchronous clear of all status, restarts acquisition
//            q          - upstream counter value (same clock domain)
//            locked     - high while the monitor is locked
//            wrap       - one-cycle pulse per detected 7->0 wrap
//            wrap_count - saturating count of wraps
//            step_err   - sticky sequence-error flag
//            err_val    - q captured at the first error
//            err_exp    - value that was expected at the first error
// Revision : 1.0 - initial release
// ============================================================================
module count_step_monitor #(
  parameter int WRAP_W   = 8,
  parameter int LOCK_CNT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [2:0]        q,
  output logic              locked,
  output logic              wrap,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              step_err,
  output logic [2:0]        err_val,
  output logic [2:0]        err_exp
);

  typedef enum logic [1:0] {
    S_SYNC   = 2'd0,
    S_ACQ    = 2'd1,
    S_LOCKED = 2'd2,
    S_FAULT  = 2'd3
  } state_t;

  localparam logic [3:0]        C_LOCK_CNT = 4'(LOCK_CNT);
  localparam logic [WRAP_W-1:0] C_WRAP_MAX = '1;

  state_t            state_q;
  logic [2:0]        prev_q;
  logic [3:0]        good_q;
  logic              locked_q;
  logic              wrap_q;
  logic [WRAP_W-1:0] wrap_count_q;
  logic [WRAP_W-1:0] wrap_count_d;
  logic              step_err_q;
  logic [2:0]        err_val_q;
  logic [2:0]        err_exp_q;

  logic [2:0]        w_prev_inc;
  logic              w_good_step;
  logic              w_is_wrap;
  logic [3:0]        w_good_inc;

  // 3-bit addition wraps naturally, giving the mod-8 successor of prev.
  assign w_prev_inc   = prev_q + 3'd1;
  assign w_good_step  = (q == w_prev_inc);
  assign w_is_wrap    = (prev_q == 3'd7) && (q == 3'd0);
  assign w_good_inc   = good_q + 4'd1;
  assign wrap_count_d = (wrap_count_q == C_WRAP_MAX) ? wrap_count_q
                                                     : wrap_count_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_SYNC;
      prev_q       <= 3'd0;
      good_q       <= 4'd0;
      locked_q     <= 1'b0;
      wrap_q       <= 1'b0;
      wrap_count_q <= '0;
      step_err_q   <= 1'b0;
      err_val_q    <= 3'd0;
      err_exp_q    <= 3'd0;
    end else begin
      // prev tracks q on every edge, including clr and FAULT cycles.
      prev_q <= q;
      wrap_q <= 1'b0;
      if (clr) begin
        state_q      <= S_SYNC;
        good_q       <= 4'd0;
        locked_q     <= 1'b0;
        wrap_count_q <= '0;
        step_err_q   <= 1'b0;
        err_val_q    <= 3'd0;
        err_exp_q    <= 3'd0;
      end else begin
        case (state_q)
          S_SYNC: begin
            // prev is only being primed here; no step is judged yet.
            state_q <= S_ACQ;
          end
          S_ACQ: begin
            if (w_good_step) begin
              if (w_good_inc == C_LOCK_CNT) begin
                state_q  <= S_LOCKED;
                locked_q <= 1'b1;
                good_q   <= 4'd0;
              end else begin
                good_q <= w_good_inc;
              end
            end else begin
              good_q <= 4'd0;
            end
          end
          S_LOCKED: begin
            if (w_good_step) begin
              if (w_is_wrap) begin
                wrap_q       <= 1'b1;
                wrap_count_q <= wrap_count_d;
              end
            end else begin
              state_q    <= S_FAULT;
              locked_q   <= 1'b0;
              step_err_q <= 1'b1;
              err_val_q  <= q;
              err_exp_q  <= w_prev_inc;
            end
          end
          S_FAULT: begin
            // Status is frozen until clr or rst.
          end
          default: begin
            state_q  <= S_SYNC;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign locked     = locked_q;
  assign wrap       = wrap_q;
  assign wrap_count = wrap_count_q;
  assign step_err   = step_err_q;
  assign err_val    = err_val_q;
  assign err_exp    = err_exp_q;

endmodule
`default_nettype wire
